soc_input_pio: RTL
==================

SOC_INPUT_PIO -- requirements
Module: soc_input_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of input bits; legal range 1-32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive differing samples needed to accept a change; legal range at least 2.
REQ-003 clk  in  1: single clock; all state on its rising edge.
REQ-004 reset_n  in  1: asynchronous, active-low reset.
REQ-005 address  in  2: Avalon-MM slave word address.
REQ-006 chipselect  in  1: slave select.
REQ-007 write_n  in  1: active-low write strobe, qualified by chipselect.
REQ-008 writedata  in  32: write data.
REQ-009 in_port  in  WIDTH: asynchronous external inputs (keys/switches).
REQ-010 readdata  out  32: read data, zero-extended above WIDTH.
REQ-011 irq  out  1: level interrupt to the processor.

Function
REQ-012 in_port SHALL pass through a two-flop synchronizer per bit before any other use.
REQ-013 Each bit SHALL have a debounce counter and a stable bit; the counter clears on any edge where the synchronized bit equals the stable bit.
REQ-014 When the synchronized bit differs from the stable bit on DEBOUNCE_CYCLES consecutive edges, the stable bit SHALL take the new value on that edge and the counter SHALL clear.
REQ-015 End-to-end latency from a stable in_port change to the stable bit changing SHALL be DEBOUNCE_CYCLES+2 edges.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave the stable bit unchanged.
REQ-017 Register map: 0 = data (RO, stable bits); 2 = interruptmask (RW, WIDTH bits); 3 = edgecapture (read, write-1-to-clear); 1 = reads 0, writes ignored.
REQ-018 Reads SHALL be zero-wait-state: readdata is combinational from address and registers and is valid in the same cycle; readdata SHALL be 0 whenever address selects an unused register.
REQ-019 A write occurs on an edge where chipselect=1 and write_n=0; writes to address 0 SHALL be ignored.
REQ-020 edgecapture bit i SHALL set on the edge where stable bit i goes 0->1; falling edges SHALL NOT set it.
REQ-021 A write to address 3 SHALL clear each edgecapture bit whose writedata bit is 1; if a set and a clear hit the same bit on the same edge, the set SHALL win.
REQ-022 irq SHALL be the OR over i of (edgecapture[i] AND interruptmask[i]), combinational from registered state and glitch-free with respect to in_port.
REQ-023 An edgecapture bit SHALL remain set until cleared, regardless of further input activity or mask changes.

Reset
REQ-024 When reset_n is low: synchronizer flops, counters, stable bits, interruptmask and edgecapture SHALL be 0, and irq SHALL be 0.
REQ-025 If in_port is 1 at reset release, the bit SHALL debounce to 1 after DEBOUNCE_CYCLES+2 edges and SHALL set edgecapture.
REQ-026 Reset asserted during a debounce count SHALL abandon the count with no stable or edgecapture update.

Structure
REQ-027 Register address constants (DATA=0, MASK=2, EDGE=3) SHALL reside in a shared package used by the PIO blocks and software-header generation.
REQ-028 Synchronizer plus debounce for one bit SHALL be the sub-module pio_debounce_bit, instantiated WIDTH times; the top level holds the register file, edge detection and irq.

Verification
REQ-029 Configuration WIDTH=4, DEBOUNCE_CYCLES=4: drive in_port 0000->0001 and hold -> read address 0 returns 0x1 first at edge 6; address 3 returns 0x1.
REQ-030 Pulse in_port[2] high for 3 cycles -> data stays 0x0, edgecapture unchanged, irq stays 0.
REQ-031 Write mask=0x1 while edgecapture=0x1 -> irq=1; write 0x1 to address 3 -> edgecapture=0x0 and irq=0 on the next cycle.
REQ-032 Clear write to address 3 with writedata 0x2 on the same edge bit 1 rises -> edgecapture bit 1 reads 1.
REQ-033 Release in_port[0] 1->0 -> data bit 0 clears after 6 edges and edgecapture does not set; write to address 0 -> data unchanged.
REQ-034 Assert reset_n low mid-count, then hold in_port=0xF across reset release -> all registers 0 during reset; data=0xF and edgecapture=0xF 6 edges after release.

Source files
------------

// File: rtl/soc_input_pio_pkg.sv
// soc_input_pio_pkg: register map and helpers shared by the input PIO blocks
// and by software-header generation.
//   PIO_ADDR_DATA   - read-only debounced input levels
//   PIO_ADDR_UNUSED - reads zero, writes ignored
//   PIO_ADDR_MASK   - interrupt mask (read/write)
//   PIO_ADDR_EDGE   - rising-edge capture (read, write-1-to-clear)
package soc_input_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA   = 2'd0;
    localparam logic [1:0] PIO_ADDR_UNUSED = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK   = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE   = 2'd3;

    // Interrupt request: any captured edge that is also unmasked.
    function automatic logic pio_irq_f(input logic [31:0] capture,
                                       input logic [31:0] mask);
        return |(capture & mask);
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: two-flop synchronizer followed by a consecutive-sample
// debouncer for one input bit.
//   clk, reset_n - clock, asynchronous active-low reset
//   in_bit       - raw asynchronous input
//   stable       - debounced level (registered)
//   rise         - high in the cycle whose closing edge moves stable 0->1
module pio_debounce_bit
    import soc_input_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             stable_r;
    logic             accept_s;

    // The current differing sample is the last one needed to accept the change.
    assign accept_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);
    assign rise     = accept_s && sync2_r;
    assign stable   = stable_r;

    // Two-flop synchronizer for the asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= in_bit;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive differing samples; accept the new level on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= '0;
            stable_r <= stable_r;
        end else if (accept_s) begin
            cnt_r    <= '0;
            stable_r <= sync2_r;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
            stable_r <= stable_r;
        end
    end

endmodule

// File: rtl/soc_input_pio.sv
// soc_input_pio: debounced input PIO with Avalon-MM slave register file,
// rising-edge capture and level interrupt.
//   clk, reset_n  - clock, asynchronous active-low reset
//   address       - word address (0 data, 1 unused, 2 mask, 3 edgecapture)
//   chipselect    - slave select
//   write_n       - active-low write strobe
//   writedata     - write data
//   in_port       - asynchronous external inputs
//   readdata      - zero-wait-state read data, zero-extended above WIDTH
//   irq           - OR of unmasked captured edges
module soc_input_pio
    import soc_input_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] clear_s;
    logic             write_s;
    logic             unused_wdata_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .in_bit (in_port[i]),
            .stable (stable_s[i]),
            .rise   (rise_s[i])
        );
    end

    assign write_s        = chipselect && !write_n;
    assign clear_s        = (write_s && (address == PIO_ADDR_EDGE)) ?
                            writedata[WIDTH-1:0] : '0;
    // Bits above WIDTH are deliberately ignored.
    assign unused_wdata_s = ^writedata;

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= '0;
        end else if (write_s && (address == PIO_ADDR_MASK)) begin
            mask_r <= writedata[WIDTH-1:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // Edge capture: a new rising edge on the same cycle as a clear keeps the bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_r <= '0;
        end else begin
            edgecap_r <= (edgecap_r & ~clear_s) | rise_s;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = 32'd0;
        case (address)
            PIO_ADDR_DATA:   readdata[WIDTH-1:0] = stable_s;
            PIO_ADDR_MASK:   readdata[WIDTH-1:0] = mask_r;
            PIO_ADDR_EDGE:   readdata[WIDTH-1:0] = edgecap_r;
            PIO_ADDR_UNUSED: readdata = 32'd0;
            default:         readdata = 32'd0;
        endcase
    end

    // Driven only from flops, so in_port activity cannot glitch it.
    assign irq = pio_irq_f(32'(edgecap_r), 32'(mask_r));

endmodule
